// File: rtl/tone_synth_if.sv
// Tone request and speaker status bundle between the decoder/bench and tone_synth.
interface tone_synth_if;
    logic [31:0] desiredFrequency;
    logic        play;
    logic        spkr;
    logic        busy;
    logic        active;

    modport master (
        output desiredFrequency,
        output play,
        input  spkr,
        input  busy,
        input  active
    );

    modport slave (
        input  desiredFrequency,
        input  play,
        output spkr,
        output busy,
        output active
    );
endinterface

// File: rtl/tone_synth.sv
// Square-wave tone generator: a 32-step restoring divider turns a frequency request
// into a half-period count; pitch changes land on half-period boundaries.
module tone_synth #(
    parameter int unsigned CLK_HZ   = 50_000_000,
    parameter int unsigned MIN_FREQ = 20,
    parameter int unsigned MAX_FREQ = 20000
) (
    input  logic         FPGA_CLK1_50,
    input  logic         reset,
    tone_synth_if.slave  tone
);
    localparam logic [31:0] CLK_VAL = 32'(CLK_HZ);
    localparam logic [31:0] MIN_VAL = 32'(MIN_FREQ);
    localparam logic [31:0] MAX_VAL = 32'(MAX_FREQ);

    typedef enum logic [1:0] {IDLE, DIVIDE, LOAD} state_t;
    state_t state_reg, state_next;

    logic [31:0] target_reg;
    logic [31:0] half_period_reg;
    logic [31:0] pending_reg;
    logic        pending_valid_reg;
    logic [31:0] cnt_reg;
    logic        spkr_reg;

    logic [31:0] dvd_reg;
    logic [31:0] quo_reg;
    logic [32:0] divisor_reg;
    logic [32:0] rem_reg;
    logic [4:0]  iter_reg;

    logic        req_valid;
    logic        req_new;
    logic        start_div;
    logic        kill;
    logic [33:0] rem_shift;
    logic [32:0] rem_diff;
    logic        rem_ge;
    logic [32:0] rem_next;
    logic        boundary;

    always_comb begin
        req_valid = (tone.desiredFrequency >= MIN_VAL) && (tone.desiredFrequency <= MAX_VAL);
        // Requests are only looked at while the divider is not iterating.
        req_new   = (state_reg != DIVIDE) && (tone.desiredFrequency != target_reg);
        start_div = req_new && req_valid;
        kill      = req_new && !req_valid;
    end

    always_comb begin
        rem_shift = {rem_reg, dvd_reg[31]};
        rem_ge    = rem_shift >= {1'b0, divisor_reg};
        rem_diff  = rem_shift[32:0] - divisor_reg;
        rem_next  = rem_ge ? rem_diff : rem_shift[32:0];
        boundary  = (cnt_reg == half_period_reg - 32'd1);
    end

    always_comb begin
        state_next = state_reg;
        case (state_reg)
            IDLE:    if (start_div) state_next = DIVIDE;
            DIVIDE:  if (iter_reg == 5'd31) state_next = LOAD;
            LOAD:    state_next = start_div ? DIVIDE : IDLE;
            default: state_next = IDLE;
        endcase
    end

    always_ff @(posedge FPGA_CLK1_50) begin
        if (reset) begin
            state_reg <= IDLE;
        end else begin
            state_reg <= state_next;
        end
    end

    always_ff @(posedge FPGA_CLK1_50) begin
        if (reset) begin
            dvd_reg     <= '0;
            quo_reg     <= '0;
            divisor_reg <= '0;
            rem_reg     <= '0;
            iter_reg    <= '0;
        end else if (start_div) begin
            dvd_reg     <= CLK_VAL;
            quo_reg     <= '0;
            divisor_reg <= {tone.desiredFrequency, 1'b0};
            rem_reg     <= '0;
            iter_reg    <= '0;
        end else if (state_reg == DIVIDE) begin
            dvd_reg  <= {dvd_reg[30:0], 1'b0};
            quo_reg  <= {quo_reg[30:0], rem_ge};
            rem_reg  <= rem_next;
            iter_reg <= iter_reg + 5'd1;
        end
    end

    // Later assignments deliberately override earlier ones: LOAD beats the
    // counter's pending hand-off, and an invalid request beats everything.
    always_ff @(posedge FPGA_CLK1_50) begin
        if (reset) begin
            target_reg        <= '0;
            half_period_reg   <= '0;
            pending_reg       <= '0;
            pending_valid_reg <= 1'b0;
            cnt_reg           <= '0;
            spkr_reg          <= 1'b0;
        end else begin
            if (req_new) begin
                target_reg <= tone.desiredFrequency;
            end

            if (!tone.play) begin
                cnt_reg  <= '0;
                spkr_reg <= 1'b0;
                if (pending_valid_reg) begin
                    half_period_reg   <= pending_reg;
                    pending_valid_reg <= 1'b0;
                end
            end else if (half_period_reg != 32'd0) begin
                if (boundary) begin
                    spkr_reg <= ~spkr_reg;
                    cnt_reg  <= '0;
                    if (pending_valid_reg) begin
                        half_period_reg   <= pending_reg;
                        pending_valid_reg <= 1'b0;
                    end
                end else begin
                    cnt_reg <= cnt_reg + 32'd1;
                end
            end

            if (state_reg == LOAD) begin
                if ((half_period_reg == 32'd0) || !tone.play) begin
                    half_period_reg   <= quo_reg;
                    cnt_reg           <= '0;
                    spkr_reg          <= 1'b0;
                    pending_valid_reg <= 1'b0;
                end else begin
                    pending_reg       <= quo_reg;
                    pending_valid_reg <= 1'b1;
                end
            end

            if (kill) begin
                half_period_reg   <= '0;
                cnt_reg           <= '0;
                spkr_reg          <= 1'b0;
                pending_valid_reg <= 1'b0;
            end
        end
    end

    assign tone.busy   = (state_reg == DIVIDE);
    assign tone.spkr   = spkr_reg;
    assign tone.active = tone.play && (half_period_reg != 32'd0);
endmodule

// File: doc/tone_synth.md
Name: tone_synth

Overview:
- Downstream of the keypad/song decoder; converts its 32-bit `desiredFrequency` (Hz) and `play` outputs into a 50%-duty square wave on the speaker pin.
- A multi-cycle restoring divider computes the half-period in clock cycles.
- Frequency changes take effect only at a half-period boundary, so pitch changes are glitch-free.
- Silence requests take effect immediately.

Parameters:
- CLK_HZ, 50_000_000, system clock frequency in Hz; the divider's dividend is 2-free (dividend = CLK_HZ, divisor = 2*f).
- MIN_FREQ, 20, lowest audible frequency accepted; below it the output is silent.
- MAX_FREQ, 20000, highest frequency accepted; above it the output is silent.

Ports:
- FPGA_CLK1_50  in   1   system clock, 50 MHz.
- reset         in   1   synchronous, active-high reset.
- desiredFrequency  in   32  requested tone in Hz, unsigned; 0 means rest.
- play          in   1   tone enable; 0 forces silence.
- spkr          out  1   square-wave drive to the speaker.
- busy          out  1   divider computing a new half-period.
- active        out  1   tone currently sounding.

Behaviour:
- One clock domain. Reset is synchronous and active-high.
- Reset values: spkr=0, busy=0, active=0. Internal registers clear: target=0, half_period=0, pending_valid=0, cnt=0, state=IDLE.
- Reset mid-divide: the in-flight result is discarded and never loaded.

Acceptance:
- A request is valid iff MIN_FREQ <= f <= MAX_FREQ.
- Each cycle with busy=0, if desiredFrequency != target, then target <= desiredFrequency.
  - If the request is invalid: no divide. Next cycle spkr=0, active=0, cnt=0, half_period=0, pending_valid=0.
  - If the request is valid: start the divide (state DIVIDE).
- While busy=1, desiredFrequency is ignored. After the divide completes, the compare repeats, so the last value written wins (no queue).

Divider FSM: states IDLE, DIVIDE, LOAD.
- IDLE -> DIVIDE on a valid new target.
- DIVIDE: restoring shift-subtract computing q = floor(CLK_HZ / (2*target)).
  - Exactly 32 iterations, one per cycle; busy=1 for exactly those 32 cycles.
  - The remainder is discarded. q is a 32-bit unsigned value, and the 2*target product is 33 bits wide.
- LOAD (1 cycle, busy=0):
  - If currently silent (half_period==0) or play=0: half_period <= q, cnt <= 0, spkr <= 0.
  - Otherwise: pending <= q, pending_valid <= 1.
  - Then return to IDLE.
- Acceptance of a new target is allowed in the LOAD cycle; the compare uses the updated target.

Tone counter (runs when play=1 and half_period != 0; active = play && half_period != 0):
- cnt increments every cycle.
- When cnt == half_period-1:
  - spkr toggles and cnt <= 0.
  - If pending_valid: half_period <= pending and pending_valid <= 0 (new period starts with the next half-cycle).
- After a fresh start from silence, the first toggle (0->1) occurs half_period cycles after the LOAD cycle.

play handling:
- play=0: next cycle spkr=0 and cnt=0, and they hold there.
- Acceptance and divides continue while play=0. A pending value is applied directly to half_period while play=0.
- play 0->1: tone restarts with cnt=0 and spkr=0.

Simultaneous events:
- An invalid request arriving while a valid one is pending (busy=0) silences immediately and clears pending_valid.
- A toggle boundary and LOAD in the same cycle: the toggle uses the old half_period, and the pending value is applied at the next boundary.

Reference values (CLK_HZ=50e6):
- 261 Hz -> 95785
- 440 Hz -> 56818
- 494 Hz -> 50607
- 330 Hz -> 75757
- 20000 Hz -> 1250

Test Plan:
- Reset held 3 cycles with desiredFrequency=440, play=1 -> spkr=0, busy=0, active=0 throughout. After release: busy=1 for exactly 32 cycles, then LOAD, then first spkr rise 56818 cycles after LOAD, then toggles every 56818 cycles, active=1.
- Steady 440 Hz, change to 494 mid half-cycle -> busy 32 cycles; the half-cycle in progress and any boundary before LOAD use 56818; the first half-cycle after the next boundary lasts 50607; no shortened or doubled edge.
- Tone at 440, then desiredFrequency=0 -> next cycle spkr=0, active=0. Then 25000 and 15 each -> silent, busy never asserts. Then 20000 -> period 2500 cycles.
- desiredFrequency=261, then 330 at busy cycle 5, then 330 held -> first divide completes and loads 95785; a second 32-cycle divide follows immediately; final half-period is 75757.
- Tone running, play=0 for 1000 cycles, frequency changed to 494 meanwhile -> spkr low within 1 cycle, divide runs and half_period becomes 50607. On play=1, first rise after 50607 cycles.
- reset asserted at divide cycle 20 of 440 Hz -> next cycle all outputs 0, no later LOAD. After release the divide restarts from cycle 1.
